// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: loads an operand, then shifts one bit per clock until the amount is used up.
// Optional rotate-right support is compiled in with SHIFT_SEQ_ROTATE_EN.
module shift_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               src_sel,
    input  logic                     amt_sel,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         in_regA,
    input  logic [WIDTH-1:0]         in_regB,
    input  logic [WIDTH-1:0]         in_immed,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic [WIDTH-1:0]         result,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AW = $clog2(WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t          state;
    logic [AW-1:0]   count;
    logic [1:0]      op_q;

    logic [WIDTH-1:0] operand_c;
    logic [AW-1:0]    amount_c;
    logic [WIDTH-1:0] step_c;

    // Operand and amount selection for the accepting edge
    always_comb begin
        operand_c = result;
        case (src_sel)
            2'b00:   operand_c = in_regA;
            2'b01:   operand_c = in_regB;
            2'b10:   operand_c = in_immed;
            default: operand_c = result;
        endcase

        amount_c = amt_sel ? in_regB[AW-1:0] : shamt;
`ifndef SHIFT_SEQ_ROTATE_EN
        // Without rotate support an ROR request degenerates to a plain load
        if (op == OP_ROR) begin
            amount_c = AW'(0);
        end
`endif
    end

    // One-bit step of the latched operation
    always_comb begin
        step_c = result;
        case (op_q)
            OP_SLL:  step_c = {result[WIDTH-2:0], 1'b0};
            OP_SRL:  step_c = {1'b0, result[WIDTH-1:1]};
            OP_SRA:  step_c = {result[WIDTH-1], result[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR:  step_c = {result[0], result[WIDTH-1:1]};
`endif
            default: step_c = result;
        endcase
    end

    // Sequencer with registered busy/done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            result <= '0;
            count  <= '0;
            op_q   <= OP_SLL;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        result <= operand_c;
                        count  <= amount_c;
                        op_q   <= op;
                        state  <= SHIFT;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (count != AW'(0)) begin
                        result <= step_c;
                        count  <= count - AW'(1);
                    end else begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed self-checking bench for shift_seq_unit (WIDTH=32); follows SHIFT_SEQ_ROTATE_EN if defined.
module tb_shift_seq_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  src_sel;
    logic        amt_sel;
    logic [1:0]  op;
    logic [31:0] in_regA;
    logic [31:0] in_regB;
    logic [31:0] in_immed;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    shift_seq_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_sel  (src_sel),
        .amt_sel  (amt_sel),
        .op       (op),
        .in_regA  (in_regA),
        .in_regB  (in_regB),
        .in_immed (in_immed),
        .shamt    (shamt),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait for done, check latency, busy length and result.
    task automatic run_op(input string tag, input logic [1:0] s, input logic a, input logic [1:0] o,
                          input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] im,
                          input logic [4:0] sh, input int exp_edges, input logic [31:0] exp_res);
        int edges;
        int busy_n;
        src_sel  = s;
        amt_sel  = a;
        op       = o;
        in_regA  = ra;
        in_regB  = rb;
        in_immed = im;
        shamt    = sh;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Operands are don't-care after the accepting edge
        in_regA  = 32'hDEAD_BEEF;
        in_regB  = 32'h5A5A_A5A5;
        in_immed = 32'hFFFF_FFFF;
        shamt    = 5'd31;
        op       = 2'b11;
        edges    = 0;
        busy_n   = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_n++;
        end
        check_eq({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_edges));
        check_eq({tag, "_result"}, 64'(result), 64'(exp_res));
    endtask

    task automatic check_idle_after(input string tag, input logic [31:0] exp_res);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse_once"}, 64'(done), 64'(0));
        check_eq({tag, "_idle_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_hold_result"}, 64'(result), 64'(exp_res));
    endtask

    initial begin
        int done_seen;
        reset    = 1'b0;
        start    = 1'b0;
        src_sel  = 2'b00;
        amt_sel  = 1'b0;
        op       = 2'b00;
        in_regA  = '0;
        in_regB  = '0;
        in_immed = '0;
        shamt    = '0;
        #12;
        check_eq("rst_result", 64'(result), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // SLL by 4 from regA, then chained SRL by 4 accepted straight out of DONE
        run_op("sll4", 2'b00, 1'b0, 2'b00, 32'h8000_0001, 32'h0, 32'h0, 5'd4, 5, 32'h0000_0010);
        run_op("chain_srl4", 2'b11, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 5'd4, 5, 32'h0000_0001);
        check_idle_after("chain", 32'h0000_0001);

        run_op("sra8_regb", 2'b01, 1'b1, 2'b10, 32'h0, 32'hF000_0008, 32'h0, 5'd0, 9, 32'hFFF0_0000);
        check_idle_after("sra8", 32'hFFF0_0000);

`ifdef SHIFT_SEQ_ROTATE_EN
        run_op("ror1", 2'b10, 1'b0, 2'b11, 32'h0, 32'h0, 32'h0000_0001, 5'd1, 2, 32'h8000_0000);
`else
        run_op("ror1", 2'b10, 1'b0, 2'b11, 32'h0, 32'h0, 32'h0000_0001, 5'd1, 1, 32'h0000_0001);
`endif

        run_op("srl0", 2'b00, 1'b0, 2'b01, 32'h1234_5678, 32'h0, 32'h0, 5'd0, 1, 32'h1234_5678);
        check_idle_after("srl0", 32'h1234_5678);

        // Reset three steps into a 10-step SLL
        src_sel = 2'b00; amt_sel = 1'b0; op = 2'b00; in_regA = 32'h0000_0001; shamt = 5'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_step3_result", 64'(result), 64'(32'h0000_0008));
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_result", 64'(result), 64'(0));
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_done", 64'(done), 64'(0));
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check_eq("abort_no_done", 64'(done_seen), 64'(0));
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op("post_rst_sra3", 2'b00, 1'b0, 2'b10, 32'h0000_00FF, 32'h0, 32'h0, 5'd3, 4, 32'h0000_001F);
        check_idle_after("post_rst", 32'h0000_001F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
